sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_frame_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame controller in front of a Sobel core: parses a 4-byte little-endian
// header, forwards pixel bytes, tracks core output and recovers from stalls.
module sobel_frame_ctrl #(
    parameter int MAX_WIDTH      = 2048,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int QUIET_CYCLES   = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        core_valid_out,
    output logic [7:0]  fwd_data,
    output logic        fwd_valid,
    output logic        core_rst,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] pix_total
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PIX,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_width;
    logic [7:0]  r_height_lo;
    logic [1:0]  r_hdr_cnt;
    logic [31:0] r_pix_cnt;
    logic [31:0] r_out_cnt;
    logic [31:0] r_timer;
    logic [31:0] r_pix_total;
    logic [1:0]  r_err_code;
    logic [7:0]  r_fwd_data;
    logic        r_fwd_valid;
    logic        r_core_rst;

    logic        w_hdr_last;
    logic [15:0] w_hdr_height;
    logic        w_hdr_ok;
    logic [31:0] w_prod;
    logic [31:0] w_pix_cnt_inc;
    logic [31:0] w_out_cnt_nxt;
    logic        w_activity;
    logic        w_timer_exp;
    logic        w_quiet_done;
    logic        w_fwd_en;
    logic [1:0]  w_err_code_nxt;

    assign w_hdr_last    = (r_state == S_HDR) && rx_valid && (r_hdr_cnt == 2'd3);
    assign w_hdr_height  = {rx_data, r_height_lo};
    assign w_hdr_ok      = (r_width != 16'd0) && (w_hdr_height != 16'd0) &&
                           (32'(r_width) <= 32'(MAX_WIDTH));
    assign w_prod        = 32'(r_width) * 32'(w_hdr_height);
    assign w_pix_cnt_inc = r_pix_cnt + 32'd1;
    assign w_fwd_en      = rx_valid &&
                           ((r_state == S_IDLE) || (r_state == S_HDR) || (r_state == S_PIX));

    // Output strobes only count while a frame is streaming, and never past the frame size.
    always_comb begin
        w_out_cnt_nxt = r_out_cnt;
        if (((r_state == S_PIX) || (r_state == S_DRAIN)) && core_valid_out &&
            (r_out_cnt < r_pix_total)) begin
            w_out_cnt_nxt = r_out_cnt + 32'd1;
        end
    end

    // One timer serves both the stall watchdog and the ERR quiet period.
    always_comb begin
        w_activity = 1'b0;
        case (r_state)
            S_HDR, S_PIX, S_ERR: w_activity = rx_valid;
            S_DRAIN:             w_activity = core_valid_out;
            default:             w_activity = 1'b0;
        endcase
    end

    assign w_timer_exp  = !w_activity && (r_timer == 32'(TIMEOUT_CYCLES - 1));
    assign w_quiet_done = !rx_valid && (r_timer == 32'(QUIET_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_state_nxt    = S_HDR;
                    w_err_code_nxt = 2'd0;
                end
            end
            S_HDR: begin
                if (w_hdr_last) begin
                    if (w_hdr_ok) begin
                        w_state_nxt = S_PIX;
                    end else begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = 2'd1;
                    end
                end else if (w_timer_exp) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = 2'd2;
                end
            end
            S_PIX: begin
                if (rx_valid && (w_pix_cnt_inc == r_pix_total)) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_timer_exp) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = 2'd2;
                end
            end
            S_DRAIN: begin
                if (w_out_cnt_nxt == r_pix_total) begin
                    w_state_nxt = S_DONE;
                end else if (w_timer_exp) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = 2'd3;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (w_quiet_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width     <= 16'd0;
            r_height_lo <= 8'd0;
            r_hdr_cnt   <= 2'd0;
            r_pix_cnt   <= 32'd0;
            r_out_cnt   <= 32'd0;
            r_timer     <= 32'd0;
            r_pix_total <= 32'd0;
            r_err_code  <= 2'd0;
            r_fwd_data  <= 8'd0;
            r_fwd_valid <= 1'b0;
            r_core_rst  <= 1'b1;
        end else begin
            r_err_code  <= w_err_code_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_fwd_valid <= w_fwd_en;
            if (w_fwd_en) begin
                r_fwd_data <= rx_data;
            end

            if ((w_state_nxt != r_state) || w_activity) begin
                r_timer <= 32'd0;
            end else begin
                r_timer <= r_timer + 32'd1;
            end

            // Core is reset on ERR entry and on every clean return to IDLE.
            r_core_rst <= ((w_state_nxt == S_ERR) && (r_state != S_ERR)) ||
                          (r_state == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_width[7:0] <= rx_data;
                        r_hdr_cnt    <= 2'd1;
                        r_pix_cnt    <= 32'd0;
                        r_out_cnt    <= 32'd0;
                    end
                end
                S_HDR: begin
                    if (rx_valid) begin
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        case (r_hdr_cnt)
                            2'd1:    r_width[15:8] <= rx_data;
                            2'd2:    r_height_lo   <= rx_data;
                            default: r_pix_total   <= w_prod;
                        endcase
                    end
                end
                S_PIX: begin
                    if (rx_valid) begin
                        r_pix_cnt <= w_pix_cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fwd_data   = r_fwd_data;
    assign fwd_valid  = r_fwd_valid;
    assign core_rst   = r_core_rst;
    assign busy       = (r_state == S_HDR) || (r_state == S_PIX) || (r_state == S_DRAIN);
    assign frame_done = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign err_code   = r_err_code;
    assign pix_total  = r_pix_total;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: forwarded bytes are queued when driven
// and popped as fwd_valid pulses appear; frame outcomes are checked per scenario.
module tb_sobel_frame_ctrl;
    localparam int TO = 40;
    localparam int QT = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        core_valid_out;
    logic [7:0]  fwd_data;
    logic        fwd_valid;
    logic        core_rst;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] pix_total;

    int n_total = 0;
    int n_bad   = 0;
    int fwd_cnt = 0;
    int done_cnt = 0;
    int crst_cnt = 0;
    int f0, d0, c0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .MAX_WIDTH     (2048),
        .TIMEOUT_CYCLES(TO),
        .QUIET_CYCLES  (QT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .core_valid_out(core_valid_out),
        .fwd_data      (fwd_data),
        .fwd_valid     (fwd_valid),
        .core_rst      (core_rst),
        .busy          (busy),
        .frame_done    (frame_done),
        .err           (err),
        .err_code      (err_code),
        .pix_total     (pix_total)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fwd_valid) begin
                fwd_cnt++;
                chk("fwd_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("fwd_data", 32'(fwd_data), 32'(exp_q.pop_front()));
            end
            if (frame_done) done_cnt++;
            if (core_rst) crst_cnt++;
        end
    end

    task automatic send(input logic [7:0] b, input bit fw, input bit cv = 1'b0);
        rx_data        = b;
        rx_valid       = 1'b1;
        core_valid_out = cv;
        if (fw) exp_q.push_back(b);
        @(posedge clk);
        #1;
        rx_valid       = 1'b0;
        core_valid_out = 1'b0;
    endtask

    task automatic strobe();
        core_valid_out = 1'b1;
        @(posedge clk);
        #1;
        core_valid_out = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [15:0] w, input logic [15:0] h);
        send(w[7:0], 1'b1);
        send(w[15:8], 1'b1);
        send(h[7:0], 1'b1);
        send(h[15:8], 1'b1);
    endtask

    task automatic snap();
        f0 = fwd_cnt;
        d0 = done_cnt;
        c0 = crst_cnt;
    endtask

    initial begin
        rst = 1'b1;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        core_valid_out = 1'b0;
        idle(3);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_pix_total", pix_total, 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        idle(3);

        // clean 4x3 frame
        snap();
        hdr(16'd4, 16'd3);
        chk("t1_pix_total", pix_total, 32'd12);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 12; i++) send(8'(i * 7 + 1), 1'b1);
        for (int i = 0; i < 12; i++) strobe();
        idle(3);
        chk("t1_fwd_cnt", 32'(fwd_cnt - f0), 32'd16);
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_core_rst", 32'(crst_cnt - c0), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // width 0x0801 exceeds MAX_WIDTH
        snap();
        hdr(16'h0801, 16'd1);
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_code", 32'(err_code), 32'd1);
        chk("t2_core_rst", 32'(core_rst), 32'd1);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        idle(2);
        chk("t2_fwd_cnt", 32'(fwd_cnt - f0), 32'd4);
        chk("t2_core_rst_cnt", 32'(crst_cnt - c0), 32'd1);
        idle(QT + 2);
        chk("t2_err_cleared", 32'(err), 32'd0);
        chk("t2_code_hold", 32'(err_code), 32'd1);

        // rx stall in PIX
        snap();
        hdr(16'd4, 16'd3);
        chk("t3_code_clr", 32'(err_code), 32'd0);
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b1);
        idle(TO - 1);
        chk("t3_no_err_yet", 32'(err), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        idle(1);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_code", 32'(err_code), 32'd2);
        idle(QT - 1);
        chk("t3_still_err", 32'(err), 32'd1);
        idle(1);
        chk("t3_idle", 32'(err), 32'd0);
        chk("t3_busy_after", 32'(busy), 32'd0);
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // core returns one strobe short
        snap();
        hdr(16'd4, 16'd3);
        for (int i = 0; i < 12; i++) send(8'(8'h80 + i), 1'b1);
        for (int i = 0; i < 11; i++) strobe();
        idle(TO + 2);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_code", 32'(err_code), 32'd3);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        idle(QT + 2);
        chk("t4_idle", 32'(err), 32'd0);

        // reset mid-frame, then a 2x2 frame with strobes alongside pixels
        hdr(16'd4, 16'd3);
        for (int i = 0; i < 6; i++) send(8'(8'hC0 + i), 1'b1);
        snap();
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_core_rst", 32'(core_rst), 32'd1);
        chk("t5_rst_pix_total", pix_total, 32'd0);
        chk("t5_rst_fwd_valid", 32'(fwd_valid), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("t5_no_done_abort", 32'(done_cnt - d0), 32'd0);
        snap();
        hdr(16'd2, 16'd2);
        chk("t5_pix_total", pix_total, 32'd4);
        for (int i = 0; i < 4; i++) send(8'(8'hE0 + i), 1'b1, 1'b1);
        idle(3);
        chk("t5_done", 32'(done_cnt - d0), 32'd1);
        chk("t5_fwd_cnt", 32'(fwd_cnt - f0), 32'd8);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
